// File: rtl/micro_sequencer_pkg.sv
// Shared constants for the micro-sequencer: fixed control states, Mode 3/4
// microcode entry bases, addressing offsets and entry-point helpers.
package micro_sequencer_pkg;

  localparam int STATE_W_DEF = 10;

  localparam int ST_RESET      = 0;
  localparam int ST_FETCH      = 1;
  localparam int ST_FETCH_REQ  = 2;
  localparam int ST_FETCH_WAIT = 3;
  localparam int ST_DECODE     = 4;

  localparam int M3_LDRD  = 202;
  localparam int M3_LDRSB = 226;
  localparam int M3_LDRSH = 250;
  localparam int M3_STRD  = 274;

  localparam int M4_LDMIA = 394;
  localparam int M4_LDMIB = 409;
  localparam int M4_LDMDA = 424;
  localparam int M4_LDMDB = 439;
  localparam int M4_STMIA = 455;
  localparam int M4_STMIB = 471;
  localparam int M4_STMDA = 487;
  localparam int M4_STMDB = 503;

  localparam int OFS_REG_OFFSET = 4;
  localparam int OFS_PRE_WB     = 8;
  localparam int OFS_POST       = 16;
  localparam int OFS_SUB        = 96;

  typedef enum logic [1:0] {RUN_NONE, RUN_M3, RUN_M4} run_e;

  // pwui = {P, U, I, W} = IR[24:21]
  function automatic int mode3_entry(input int base, input logic [3:0] pwui);
    int e;
    e = base;
    if (!pwui[1])            e = e + OFS_REG_OFFSET;
    if (pwui[3] && pwui[0])  e = e + OFS_PRE_WB;
    if (!pwui[3] && !pwui[0]) e = e + OFS_POST;
    if (!pwui[2])            e = e + OFS_SUB;
    return e;
  endfunction

  function automatic int mode4_base(input logic l, input logic p, input logic u);
    int b;
    case ({l, p, u})
      3'b101:  b = M4_LDMIA;
      3'b111:  b = M4_LDMIB;
      3'b100:  b = M4_LDMDA;
      3'b110:  b = M4_LDMDB;
      3'b001:  b = M4_STMIA;
      3'b011:  b = M4_STMIB;
      3'b000:  b = M4_STMDA;
      default: b = M4_STMDB;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Bus between the instruction pipeline / memory system and the micro-sequencer.
interface micro_sequencer_if #(
  parameter int STATE_W = micro_sequencer_pkg::STATE_W_DEF
);
  // No valid/ready pair here: MOC is a level the sequencer samples only in a
  // MOC-wait state, IR/Cond only in decode; all outputs are registered.
  logic [31:0]        IR;
  logic               Cond;
  logic               MOC;
  logic [STATE_W-1:0] state;
  logic [3:0]         regIdx;
  logic               dblPhase;
  logic               memTimeout;
  logic               undef;
  logic               condSkip;

  modport master (
    output IR, Cond, MOC,
    input  state, regIdx, dblPhase, memTimeout, undef, condSkip
  );

  modport slave (
    input  IR, Cond, MOC,
    output state, regIdx, dblPhase, memTimeout, undef, condSkip
  );
endinterface

// File: rtl/micro_sequencer_reg_list_scanner.sv
// Finds the next set bit of a 16-bit register list strictly beyond cur,
// scanning upward (up=1) or downward (up=0).
module reg_list_scanner (
  input  logic [15:0] list,
  input  logic [3:0]  cur,
  input  logic        up,
  output logic [3:0]  next_idx,
  output logic        found
);
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    if (up) begin
      for (int i = 15; i >= 0; i--) begin
        if (list[4'(i)] && (4'(i) > cur)) begin
          next_idx = 4'(i);
          found    = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (list[4'(i)] && (4'(i) < cur)) begin
          next_idx = 4'(i);
          found    = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/micro_sequencer.sv
// Microcoded control sequencer: fetch, decode, Mode 3 (LDRD/STRD/LDRSB/LDRSH)
// and Mode 4 (LDM/STM) runs, with a shared MOC timeout and abort path.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int                 STATE_W  = STATE_W_DEF,
  parameter int                 TMO_W    = 4,
  parameter logic [STATE_W-1:0] ABORT_ST = '1
) (
  input logic              clk,
  input logic              rst_n,
  micro_sequencer_if.slave bus
);
  typedef logic [STATE_W-1:0] st_t;

  localparam st_t S_RESET      = st_t'(ST_RESET);
  localparam st_t S_FETCH      = st_t'(ST_FETCH);
  localparam st_t S_FETCH_REQ  = st_t'(ST_FETCH_REQ);
  localparam st_t S_FETCH_WAIT = st_t'(ST_FETCH_WAIT);
  localparam st_t S_DECODE     = st_t'(ST_DECODE);
  // Firing one count early makes the wait last exactly 2**TMO_W-1 cycles.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);

  st_t              state_q, state_d, base_q, base_d, b1, b2, b3, b4;
  logic [3:0]       reg_idx_q, reg_idx_d, scan_cur, scan_next, first_idx;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [15:0]      list_q, list_d;
  run_e             run_q, run_d;
  logic dbl_q, dbl_d, dbl_op_q, dbl_op_d, up_q, up_d, wb_q, wb_d;
  logic tmo_pls_q, tmo_pls_d, undef_q, undef_d, skip_q, skip_d;
  logic scan_found, at_m4_base, moc_wait;
  int   m3_base;

  assign b1 = base_q + st_t'(1);
  assign b2 = base_q + st_t'(2);
  assign b3 = base_q + st_t'(3);
  assign b4 = base_q + st_t'(4);

  assign at_m4_base = (run_q == RUN_M4) && (state_q == base_q);
  assign scan_cur   = at_m4_base ? (up_q ? 4'd0 : 4'd15) : reg_idx_q;
  // The scanner is exclusive of cur, so the end bit is tested directly here.
  assign first_idx  = up_q ? (list_q[0] ? 4'd0 : scan_next)
                           : (list_q[15] ? 4'd15 : scan_next);

  reg_list_scanner u_scan (
    .list     (list_q),
    .cur      (scan_cur),
    .up       (up_q),
    .next_idx (scan_next),
    .found    (scan_found)
  );

  always_comb begin
    state_d   = S_FETCH;
    reg_idx_d = reg_idx_q;
    dbl_d     = dbl_q;
    tmo_d     = '0;
    tmo_pls_d = 1'b0;
    undef_d   = 1'b0;
    skip_d    = 1'b0;
    run_d     = run_q;
    base_d    = base_q;
    dbl_op_d  = dbl_op_q;
    list_d    = list_q;
    up_d      = up_q;
    wb_d      = wb_q;
    moc_wait  = 1'b0;
    m3_base   = 0;
    if (state_q == S_RESET) begin
      state_d = S_FETCH;
    end else if (state_q == S_FETCH) begin
      state_d = S_FETCH_REQ;
    end else if (state_q == S_FETCH_REQ) begin
      state_d = S_FETCH_WAIT;
    end else if (state_q == S_FETCH_WAIT) begin
      moc_wait = 1'b1;
      state_d  = S_DECODE;
    end else if (state_q == S_DECODE) begin
      run_d = RUN_NONE;
      dbl_d = 1'b0;
      if (!bus.Cond) begin
        skip_d = 1'b1;
      end else if (bus.IR[27:25] == 3'b000 && bus.IR[7] && bus.IR[4]) begin
        if (!bus.IR[6]) begin
          undef_d = 1'b1;
        end else begin
          m3_base  = bus.IR[20] ? (bus.IR[5] ? M3_LDRSH : M3_LDRSB)
                                : (bus.IR[5] ? M3_STRD  : M3_LDRD);
          run_d    = RUN_M3;
          base_d   = st_t'(mode3_entry(m3_base, bus.IR[24:21]));
          dbl_op_d = !bus.IR[20];
          state_d  = base_d;
        end
      end else if (bus.IR[27:25] == 3'b100) begin
        run_d   = RUN_M4;
        base_d  = st_t'(mode4_base(bus.IR[20], bus.IR[24], bus.IR[23]));
        list_d  = bus.IR[15:0];
        up_d    = bus.IR[23];
        wb_d    = bus.IR[21];
        state_d = base_d;
      end else begin
        undef_d = 1'b1;
      end
    end else if (state_q == ABORT_ST) begin
      state_d = S_FETCH;
    end else if (run_q == RUN_M3) begin
      if (state_q == base_q) begin
        state_d = b1;
      end else if (state_q == b1) begin
        state_d = b2;
      end else if (state_q == b2) begin
        moc_wait = 1'b1;
        state_d  = b3;
      end else if (state_q == b3) begin
        if (dbl_op_q && !dbl_q) begin
          dbl_d   = 1'b1;
          state_d = b1;
        end else begin
          dbl_d = 1'b0;
        end
      end
    end else if (run_q == RUN_M4) begin
      if (state_q == base_q) begin
        if (list_q == 16'h0000) begin
          undef_d = 1'b1;
        end else begin
          reg_idx_d = first_idx;
          state_d   = b1;
        end
      end else if (state_q == b1) begin
        state_d = b2;
      end else if (state_q == b2) begin
        moc_wait = 1'b1;
        state_d  = b3;
      end else if (state_q == b3) begin
        if (scan_found) begin
          reg_idx_d = scan_next;
          state_d   = b1;
        end else if (wb_q) begin
          state_d = b4;
        end
      end
    end
    if (moc_wait && !bus.MOC) begin
      if (tmo_q == TMO_LAST) begin
        state_d   = ABORT_ST;
        tmo_pls_d = 1'b1;
        dbl_d     = 1'b0;
      end else begin
        state_d = state_q;
        tmo_d   = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      reg_idx_q <= '0;
      dbl_q     <= 1'b0;
      tmo_q     <= '0;
      tmo_pls_q <= 1'b0;
      undef_q   <= 1'b0;
      skip_q    <= 1'b0;
      run_q     <= RUN_NONE;
      base_q    <= '0;
      dbl_op_q  <= 1'b0;
      list_q    <= '0;
      up_q      <= 1'b0;
      wb_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      reg_idx_q <= reg_idx_d;
      dbl_q     <= dbl_d;
      tmo_q     <= tmo_d;
      tmo_pls_q <= tmo_pls_d;
      undef_q   <= undef_d;
      skip_q    <= skip_d;
      run_q     <= run_d;
      base_q    <= base_d;
      dbl_op_q  <= dbl_op_d;
      list_q    <= list_d;
      up_q      <= up_d;
      wb_q      <= wb_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.regIdx     = reg_idx_q;
  assign bus.dblPhase   = dbl_q;
  assign bus.memTimeout = tmo_pls_q;
  assign bus.undef      = undef_q;
  assign bus.condSkip   = skip_q;
endmodule
